piso_tx: RTL and testbench

Parallel-in serial-out transmitter that drives a single-bit serial data line into a D-flip-flop-based capture stage. It accepts a WIDTH-bit word over a valid/ready handshake and emits it one bit per clock, with a frame strobe and a last-bit marker. It sits upstream of the serial capture flops and is the producer end of that one-bit link.

---
 rtl/piso_pkg.sv | 18 +
 rtl/piso_bit_cnt.sv | 31 +++
 rtl/piso_tx.sv | 160 ++++++++++++++++
 tb/tb_piso_tx.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/piso_pkg.sv
// Shared types and constants for the piso_tx serial transmitter.
// Holds the FSM state encoding, counter sizing helper and default idle line level.
package piso_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  localparam bit IDLE_LEVEL_DEF = 1'b0;

  // Bit index counter needs clog2(WIDTH) bits, but never fewer than one.
  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/piso_bit_cnt.sv
// Bit index counter for piso_tx: zero-latency is_last flag, count updates on the next edge.
// No backpressure; clear has priority over inc, and the count never wraps on its own.
module piso_bit_cnt
  import piso_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CW    = cnt_width(WIDTH)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          clear,
  input  logic          inc,
  output logic [CW-1:0] count,
  output logic          is_last
);

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

  assign is_last = (count == LAST);

endmodule

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter; first bit on d_out one edge after accept, optional parity under PISO_TX_PARITY_EN.
// Valid/ready input: ready in IDLE and in the final serial cycle, so back-to-back frames leave no gap.
module piso_tx
  import piso_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = IDLE_LEVEL_DEF
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  output logic             ready_out,
  output logic             d_out,
  output logic             frame_out,
  output logic             last_out
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sreg, sreg_nxt, sreg_shift, load_rest;
  logic             first_bit, shift_bit;
  logic             d_nxt, frame_nxt;
  logic             accept, cnt_clear, cnt_inc, is_last;
  logic [CW-1:0]    count;
`ifdef PISO_TX_PARITY_EN
  logic             par_q, par_nxt;
`endif

  piso_bit_cnt #(.WIDTH(WIDTH), .CW(CW)) u_bit_cnt (
    .clk     (clk),
    .rstn    (rstn),
    .clear   (cnt_clear),
    .inc     (cnt_inc),
    .count   (count),
    .is_last (is_last)
  );

  // sreg holds only the bits still to be sent; d_out already carries the current one.
  generate
    if (MSB_FIRST) begin : g_msb
      assign first_bit  = data_in[WIDTH-1];
      assign load_rest  = {data_in[WIDTH-2:0], 1'b0};
      assign shift_bit  = sreg[WIDTH-1];
      assign sreg_shift = {sreg[WIDTH-2:0], 1'b0};
    end else begin : g_lsb
      assign first_bit  = data_in[0];
      assign load_rest  = {1'b0, data_in[WIDTH-1:1]};
      assign shift_bit  = sreg[0];
      assign sreg_shift = {1'b0, sreg[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    ready_out = 1'b0;
    last_out  = 1'b0;
    if (rstn) begin
      case (state)
        IDLE:   ready_out = 1'b1;
`ifdef PISO_TX_PARITY_EN
        PARITY: begin
          ready_out = 1'b1;
          last_out  = 1'b1;
        end
`else
        SHIFT: begin
          ready_out = is_last;
          last_out  = is_last;
        end
`endif
        default: begin
          ready_out = 1'b0;
          last_out  = 1'b0;
        end
      endcase
    end
  end

  assign accept = valid_in & ready_out;

  always_comb begin
    state_nxt = state;
    sreg_nxt  = sreg;
    d_nxt     = d_out;
    frame_nxt = frame_out;
    cnt_clear = 1'b0;
    cnt_inc   = 1'b0;
`ifdef PISO_TX_PARITY_EN
    par_nxt   = par_q;
`endif
    if (accept) begin
      state_nxt = SHIFT;
      sreg_nxt  = load_rest;
      d_nxt     = first_bit;
      frame_nxt = 1'b1;
      cnt_clear = 1'b1;
`ifdef PISO_TX_PARITY_EN
      par_nxt   = ^data_in;
`endif
    end else begin
      case (state)
        SHIFT: begin
          if (is_last) begin
`ifdef PISO_TX_PARITY_EN
            state_nxt = PARITY;
            d_nxt     = par_q;
`else
            state_nxt = IDLE;
            d_nxt     = IDLE_LEVEL;
            frame_nxt = 1'b0;
`endif
          end else begin
            sreg_nxt = sreg_shift;
            d_nxt    = shift_bit;
            cnt_inc  = 1'b1;
          end
        end
`ifdef PISO_TX_PARITY_EN
        PARITY: begin
          state_nxt = IDLE;
          d_nxt     = IDLE_LEVEL;
          frame_nxt = 1'b0;
        end
`endif
        default: begin
          state_nxt = IDLE;
          d_nxt     = IDLE_LEVEL;
          frame_nxt = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      sreg      <= '0;
      d_out     <= IDLE_LEVEL;
      frame_out <= 1'b0;
`ifdef PISO_TX_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      sreg      <= sreg_nxt;
      d_out     <= d_nxt;
      frame_out <= frame_nxt;
`ifdef PISO_TX_PARITY_EN
      par_q     <= par_nxt;
`endif
    end
  end

  // The bit index stays inside the word while a frame is shifting.
  a_count_range: assert property (@(posedge clk) disable iff (!rstn)
    (state == SHIFT) |-> (int'(count) <= WIDTH - 1));

endmodule

// File: tb/tb_piso_tx.sv
// Directed self-checking bench for piso_tx: MSB-first and LSB-first instances on one clock.
module tb_piso_tx;

  logic       clk;
  logic       rstn;
  logic [7:0] data_in, data_l;
  logic       valid_in, valid_l;
  logic       ready_out, d_out, frame_out, last_out;
  logic       ready_l, d_l, frame_l, last_l;

  int checks = 0;
  int errors = 0;

  piso_tx #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_msb (
    .clk       (clk),
    .rstn      (rstn),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .d_out     (d_out),
    .frame_out (frame_out),
    .last_out  (last_out)
  );

  piso_tx #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u_lsb (
    .clk       (clk),
    .rstn      (rstn),
    .data_in   (data_l),
    .valid_in  (valid_l),
    .ready_out (ready_l),
    .d_out     (d_l),
    .frame_out (frame_l),
    .last_out  (last_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [3:0] got;
    rstn = 1'b0;
    tick();
    tick();
    got = {d_out, frame_out, last_out, ready_out};
    checks++;
    if (got !== 4'b0000) begin
      errors++;
      $display("FAIL reset_msb {d,frame,last,ready}: got %b expected 0000", got);
    end
    got = {d_l, frame_l, last_l, ready_l};
    checks++;
    if (got !== 4'b0000) begin
      errors++;
      $display("FAIL reset_lsb {d,frame,last,ready}: got %b expected 0000", got);
    end
    rstn = 1'b1;
    #1;
    checks++;
    if (ready_out !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b expected 1", ready_out);
    end
  endtask

  task automatic test_single();
    logic [7:0] w;
    logic [3:0] got, exp;
    w = 8'hA5;
    data_in  = w;
    valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    for (int i = 0; i < 8; i++) begin
      exp = {w[7-i], 1'b1, (i == 7), (i == 7)};
      got = {d_out, frame_out, last_out, ready_out};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL single_bit%0d {d,frame,last,ready}: got %b expected %b", i, got, exp);
      end
      tick();
    end
    got = {d_out, frame_out, last_out, ready_out};
    checks++;
    if (got !== 4'b0001) begin
      errors++;
      $display("FAIL single_idle {d,frame,last,ready}: got %b expected 0001", got);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] s;
    logic [3:0]  got, exp;
    logic        edge_bit;
    s = 16'hA53C;
    data_in  = 8'hA5;
    valid_in = 1'b1;
    tick();
    data_in = 8'h3C;
    for (int i = 0; i < 16; i++) begin
      edge_bit = (i == 7) || (i == 15);
      exp = {s[15-i], 1'b1, edge_bit, edge_bit};
      got = {d_out, frame_out, last_out, ready_out};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL b2b_bit%0d {d,frame,last,ready}: got %b expected %b", i, got, exp);
      end
      tick();
      if (i == 7) valid_in = 1'b0;
    end
    got = {d_out, frame_out, last_out, ready_out};
    checks++;
    if (got !== 4'b0001) begin
      errors++;
      $display("FAIL b2b_idle {d,frame,last,ready}: got %b expected 0001", got);
    end
  endtask

  task automatic test_valid_busy();
    logic [3:0] got, exp;
    data_in  = 8'h00;
    valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 2) begin
        data_in  = 8'hFF;
        valid_in = 1'b1;
      end
      exp = {1'b0, 1'b1, (i == 7), (i == 7)};
      got = {d_out, frame_out, last_out, ready_out};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL busy_bit%0d {d,frame,last,ready}: got %b expected %b", i, got, exp);
      end
      tick();
      if (i == 2) begin
        valid_in = 1'b0;
        data_in  = 8'h00;
      end
    end
    for (int i = 0; i < 3; i++) begin
      got = {d_out, frame_out, last_out, ready_out};
      checks++;
      if (got !== 4'b0001) begin
        errors++;
        $display("FAIL busy_after%0d {d,frame,last,ready}: got %b expected 0001", i, got);
      end
      tick();
    end
  endtask

  task automatic test_reset_midframe();
    logic [3:0] got;
    data_in  = 8'hA5;
    valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    tick();
    tick();
    tick();
    rstn = 1'b0;
    #1;
    checks++;
    if (ready_out !== 1'b0) begin
      errors++;
      $display("FAIL midrst_ready_forced: got %b expected 0", ready_out);
    end
    tick();
    got = {d_out, frame_out, last_out, ready_out};
    checks++;
    if (got !== 4'b0000) begin
      errors++;
      $display("FAIL midrst_abort {d,frame,last,ready}: got %b expected 0000", got);
    end
    rstn = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      got = {d_out, frame_out, last_out, ready_out};
      checks++;
      if (got !== 4'b0001) begin
        errors++;
        $display("FAIL midrst_release%0d {d,frame,last,ready}: got %b expected 0001", i, got);
      end
      tick();
    end
  endtask

  task automatic test_lsb_first();
    logic [3:0] got, exp;
    data_l  = 8'h01;
    valid_l = 1'b1;
    tick();
    valid_l = 1'b0;
    for (int i = 0; i < 8; i++) begin
      exp = {(i == 0), 1'b1, (i == 7), (i == 7)};
      got = {d_l, frame_l, last_l, ready_l};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL lsb_bit%0d {d,frame,last,ready}: got %b expected %b", i, got, exp);
      end
      tick();
    end
    got = {d_l, frame_l, last_l, ready_l};
    checks++;
    if (got !== 4'b0001) begin
      errors++;
      $display("FAIL lsb_idle {d,frame,last,ready}: got %b expected 0001", got);
    end
  endtask

`ifdef PISO_TX_PARITY_EN
  task automatic test_parity(input logic [7:0] w, input logic par);
    logic [3:0] got, exp;
    data_in  = w;
    valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    for (int i = 0; i < 9; i++) begin
      exp = {((i < 8) ? w[7-i] : par), 1'b1, (i == 8), (i == 8)};
      got = {d_out, frame_out, last_out, ready_out};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL parity_%h_bit%0d {d,frame,last,ready}: got %b expected %b", w, i, got, exp);
      end
      tick();
    end
    got = {d_out, frame_out, last_out, ready_out};
    checks++;
    if (got !== 4'b0001) begin
      errors++;
      $display("FAIL parity_%h_idle {d,frame,last,ready}: got %b expected 0001", w, got);
    end
  endtask
`endif

  initial begin
    rstn     = 1'b0;
    data_in  = 8'h00;
    valid_in = 1'b0;
    data_l   = 8'h00;
    valid_l  = 1'b0;
    #1;
    test_reset();
    test_single();
    test_back_to_back();
    test_valid_busy();
    test_reset_midframe();
    test_lsb_first();
`ifdef PISO_TX_PARITY_EN
    test_parity(8'hA5, 1'b0);
    test_parity(8'hA4, 1'b1);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
